// File: rtl/dw2_calc.sv
// dw2_calc: delta-weight generator for one output-layer weight.
// Four-stage pipeline: input register, Q10 product, scaled accumulate with
// batch counting, and a negate/saturate output stage that drives dw plus a
// one-cycle dw_valid strobe for the weight register's select_update.
module dw2_calc #(
    parameter int LR_SHIFT = 3,   // eta = 2^-LR_SHIFT
    parameter int BATCH    = 1,   // samples per update, 1..255
    parameter int ACC_W    = 24   // signed accumulator width, Q(ACC_W-10).10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] delta_in,
    input  logic signed [15:0] act_in,
    input  logic               in_valid,
    input  logic               flush,
    output logic signed [15:0] dw,
    output logic               dw_valid,
    output logic [7:0]         batch_cnt
);

    // Wide enough for acc + shifted product without overflow before clamping.
    localparam int EXT_W = ((ACC_W > 32) ? ACC_W : 32) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX_EXT = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN_EXT = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   DW_MAX      = {{(ACC_W-14){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W:0]   DW_MIN      = {{(ACC_W-14){1'b1}}, {15{1'b0}}};

    logic signed [15:0]      delta_r;
    logic signed [15:0]      act_r;
    logic                    v1;
    logic signed [31:0]      prod;
    logic signed [31:0]      prod_q10;
    logic                    v2;
    logic signed [31:0]      scaled;
    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] scaled_ext;
    logic signed [EXT_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] close_sum;
    logic                    v3;
    logic                    batch_done;
    logic signed [ACC_W:0]   close_ext;
    logic signed [ACC_W:0]   neg_ext;
    logic signed [15:0]      dw_next;

    // S1: capture the incoming sample; flush drops a coincident sample.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            delta_r <= '0;
            act_r   <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                delta_r <= delta_in;
                act_r   <= act_in;
            end
        end
    end

    // Full-precision Q12.20 product of the registered operands.
    always_comb begin
        prod = $signed({{16{delta_r[15]}}, delta_r}) * $signed({{16{act_r[15]}}, act_r});
    end

    // S2: rescale the product to Q12.10 with a flooring arithmetic shift.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            prod_q10 <= '0;
            v2       <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                prod_q10 <= prod >>> 10;
            end
        end
    end

    // Learning-rate scaling, saturating accumulate and batch-close detection.
    always_comb begin
        scaled     = prod_q10 >>> LR_SHIFT;
        acc_ext    = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc};
        scaled_ext = {{(EXT_W-32){scaled[31]}}, scaled};
        sum_ext    = acc_ext + scaled_ext;
        if (sum_ext > ACC_MAX_EXT) begin
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (sum_ext < ACC_MIN_EXT) begin
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_next = sum_ext[ACC_W-1:0];
        end
        batch_done = (batch_cnt == 8'(BATCH - 1));
    end

    // S3: accumulate; on batch close restart from zero and hand the sum to S4.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            acc       <= '0;
            batch_cnt <= '0;
            close_sum <= '0;
            v3        <= 1'b0;
        end else begin
            v3 <= 1'b0;
            if (v2) begin
                if (batch_done) begin
                    acc       <= '0;
                    batch_cnt <= '0;
                    close_sum <= acc_next;
                    v3        <= 1'b1;
                end else begin
                    acc       <= acc_next;
                    batch_cnt <= batch_cnt + 8'd1;
                end
            end
        end
    end

    // Negate the closing sum; the extra bit keeps -min representable before clamping.
    always_comb begin
        close_ext = {close_sum[ACC_W-1], close_sum};
        neg_ext   = -close_ext;
        if (neg_ext > DW_MAX) begin
            dw_next = 16'sh7FFF;
        end else if (neg_ext < DW_MIN) begin
            dw_next = 16'sh8000;
        end else begin
            dw_next = neg_ext[15:0];
        end
    end

    // S4: publish the result; dw holds between pulses and across a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            dw       <= '0;
            dw_valid <= 1'b0;
        end else if (flush) begin
            dw_valid <= 1'b0;
        end else begin
            dw_valid <= v3;
            if (v3) begin
                dw <= dw_next;
            end
        end
    end

endmodule

// File: tb/tb_dw2_calc.sv
// Scoreboard bench for dw2_calc: four instances with different BATCH /
// LR_SHIFT / ACC_W share one stimulus stream; an arithmetic reference model
// predicts each update pulse (value and cycle), a negedge monitor checks them.
module tb_dw2_calc;

    localparam int NI = 4;

    int bat[NI] = '{1, 4, 1, 3};
    int lrs[NI] = '{3, 3, 0, 0};
    int acw[NI] = '{24, 24, 24, 20};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] delta_in = '0;
    logic [15:0] act_in = '0;

    logic [15:0] dw_o [NI];
    logic        dv_o [NI];
    logic [7:0]  bc_o [NI];

    always #5 clk = ~clk;

    dw2_calc #(.LR_SHIFT(3), .BATCH(1), .ACC_W(24)) u0 (
        .clk(clk), .reset(reset), .delta_in(delta_in), .act_in(act_in), .in_valid(in_valid),
        .flush(flush), .dw(dw_o[0]), .dw_valid(dv_o[0]), .batch_cnt(bc_o[0]));
    dw2_calc #(.LR_SHIFT(3), .BATCH(4), .ACC_W(24)) u1 (
        .clk(clk), .reset(reset), .delta_in(delta_in), .act_in(act_in), .in_valid(in_valid),
        .flush(flush), .dw(dw_o[1]), .dw_valid(dv_o[1]), .batch_cnt(bc_o[1]));
    dw2_calc #(.LR_SHIFT(0), .BATCH(1), .ACC_W(24)) u2 (
        .clk(clk), .reset(reset), .delta_in(delta_in), .act_in(act_in), .in_valid(in_valid),
        .flush(flush), .dw(dw_o[2]), .dw_valid(dv_o[2]), .batch_cnt(bc_o[2]));
    dw2_calc #(.LR_SHIFT(0), .BATCH(3), .ACC_W(20)) u3 (
        .clk(clk), .reset(reset), .delta_in(delta_in), .act_in(act_in), .in_valid(in_valid),
        .flush(flush), .dw(dw_o[3]), .dw_valid(dv_o[3]), .batch_cnt(bc_o[3]));

    typedef struct {
        logic [15:0] v;
        int          c;
    } exp_t;

    exp_t        q [NI][$];
    longint      m_acc [NI];
    int          m_cnt [NI];
    logic [15:0] m_last [NI];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s u%0d cycle %0d: got %h expected %h", nm, i, cyc, a, e);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Reference: dw = -sum(floor(floor(d*a/2^10)/2^L)), clamped per step, one pulse per batch.
    function automatic void m_sample(input logic [15:0] d, input logic [15:0] a, input int pulse_cyc);
        for (int i = 0; i < NI; i++) begin
            longint p;
            longint hi;
            exp_t   e;
            p  = longint'($signed(d)) * longint'($signed(a));
            p  = (p >>> 10) >>> lrs[i];
            hi = (longint'(1) << (acw[i] - 1)) - 1;
            m_acc[i] = m_acc[i] + p;
            if (m_acc[i] > hi) m_acc[i] = hi;
            if (m_acc[i] < -hi - 1) m_acc[i] = -hi - 1;
            m_cnt[i]++;
            if (m_cnt[i] == bat[i]) begin
                e.v = sat16(-m_acc[i]);
                e.c = pulse_cyc;
                q[i].push_back(e);
                m_acc[i] = 0;
                m_cnt[i] = 0;
            end
        end
    endfunction

    function automatic void m_clear(input bit clr_dw);
        for (int i = 0; i < NI; i++) begin
            q[i].delete();
            m_acc[i] = 0;
            m_cnt[i] = 0;
            if (clr_dw) m_last[i] = '0;
        end
    endfunction

    // Monitor: every pulse must match the head of its queue in value and cycle;
    // between pulses dw must hold the last published value.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (dv_o[i] === 1'b1) begin
                if (q[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse u%0d cycle %0d: got dw=%h expected no pulse", i, cyc, dw_o[i]);
                end else begin
                    e = q[i].pop_front();
                    chk("dw_value", i, {16'h0, dw_o[i]}, {16'h0, e.v});
                    chk("pulse_cycle", i, cyc, e.c);
                    m_last[i] = e.v;
                end
            end else begin
                chk("dw_hold", i, {16'h0, dw_o[i]}, {16'h0, m_last[i]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] a);
        delta_in = d;
        act_in   = a;
        in_valid = 1'b1;
        m_sample(d, a, cyc + 4);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input bit with_sample);
        flush    = 1'b1;
        in_valid = with_sample;
        delta_in = 16'($urandom);
        act_in   = 16'($urandom);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        m_clear(1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        m_clear(1'b1);
    endtask

    task automatic check_cnt(input string nm);
        for (int i = 0; i < NI; i++) chk(nm, i, {24'h0, bc_o[i]}, m_cnt[i]);
    endtask

    function automatic logic [15:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 4095)) - 16'd2048;
    endfunction

    initial begin
        m_clear(1'b1);
        idle(2);
        reset = 1'b0;
        idle(1);
        check_cnt("reset_batch_cnt");

        // Single sample, BATCH=1: 1.0 * 0.5 -> -0.0625 on u0.
        send(16'h0400, 16'h0200);
        idle(5);
        check_cnt("t1_cnt");

        // Fresh batches, then four spaced samples: u1 closes on the 4th.
        do_flush(1'b0);
        for (int k = 0; k < 4; k++) begin
            send(16'h0400, 16'h0100);
            idle(2);
            check_cnt("t2_cnt");
        end
        idle(3);

        // Saturation at the output stage (u2) and in a narrow accumulator (u3).
        send(16'h7FFF, 16'h7FFF);
        idle(4);
        send(16'h8000, 16'h7FFF);
        idle(4);
        send(16'h8000, 16'h8000);
        idle(4);
        check_cnt("t3_cnt");

        // Back-to-back samples, no bubbles.
        do_flush(1'b0);
        send(16'h0400, 16'h0400);
        send(16'h0400, 16'h0800);
        send(16'h0400, 16'hFC00);
        send(16'h0400, 16'h0000);
        send(16'h0400, 16'h0200);
        idle(5);
        check_cnt("t4_cnt");

        // Two samples discarded by a flush with a coincident sample, then a clean batch.
        do_flush(1'b0);
        send(16'h1234, 16'h2345);
        send(16'hE000, 16'h3000);
        do_flush(1'b1);
        idle(4);
        check_cnt("t5_flush_cnt");
        for (int k = 0; k < 4; k++) send(16'h0400, 16'h0100);
        idle(5);
        check_cnt("t5_cnt");

        // Reset while a sample sits in S2: dw clears and no pulse appears.
        send(16'h0400, 16'h0800);
        idle(1);
        do_reset();
        idle(5);
        check_cnt("t6_cnt");

        // Randomised traffic with occasional flush and reset.
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) send(rnd_val(), rnd_val());
            else if (r < 90) step();
            else if (r < 98) do_flush(1'($urandom_range(0, 1)));
            else do_reset();
        end
        idle(6);
        check_cnt("final_cnt");
        for (int i = 0; i < NI; i++) chk("missing_pulses", i, q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
